// File: rtl/cond_flag_unit_pkg.sv
// cond_flag_unit_pkg: condition codes, NZCV bit positions and flag_w half-select indices.
package cond_flag_unit_pkg;
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;
    localparam int FLAG_N    = 3;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_C    = 1;
    localparam int FLAG_V    = 0;
    localparam int FLAG_W_NZ = 1;
    localparam int FLAG_W_CV = 0;
endpackage

// File: rtl/cond_flag_unit_if.sv
// cond_flag_unit_if: decoder/ALU-to-flag-unit bundle; COND_FLAG_SAVE_EN adds the save/restore signals.
interface cond_flag_unit_if #(
    parameter int CNT_W = 16
);
    logic             instr_valid;
    logic [3:0]       cond;
    logic [3:0]       alu_flags;
    logic [1:0]       flag_w;
    logic             pcs;
    logic             reg_w;
    logic             mem_w;
    logic             no_write;
    logic             cnt_clr;
    logic             cond_ex;
    logic             pc_src;
    logic             reg_write;
    logic             mem_write;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] annul_cnt;
`ifdef COND_FLAG_SAVE_EN
    logic             save_req;
    logic             restore_req;
    logic [3:0]       flags_saved;
    modport master (
        output instr_valid, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write, cnt_clr,
               save_req, restore_req,
        input  cond_ex, pc_src, reg_write, mem_write, flags_q, annul_cnt, flags_saved
    );
    modport slave (
        input  instr_valid, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write, cnt_clr,
               save_req, restore_req,
        output cond_ex, pc_src, reg_write, mem_write, flags_q, annul_cnt, flags_saved
    );
`else
    modport master (
        output instr_valid, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write, cnt_clr,
        input  cond_ex, pc_src, reg_write, mem_write, flags_q, annul_cnt
    );
    modport slave (
        input  instr_valid, cond, alu_flags, flag_w, pcs, reg_w, mem_w, no_write, cnt_clr,
        output cond_ex, pc_src, reg_write, mem_write, flags_q, annul_cnt
    );
`endif
endinterface

// File: rtl/cond_flag_unit_cond_check.sv
// cond_check: combinational ARM condition-field evaluation against {N,Z,C,V}.
module cond_check
    import cond_flag_unit_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);
    logic n, z, c, v;
    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];
    always_comb begin
        pass_o = 1'b1;
        case (cond_i)
            COND_EQ: pass_o = z;
            COND_NE: pass_o = ~z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = ~c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = ~n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = ~v;
            COND_HI: pass_o = c & ~z;
            COND_LS: pass_o = ~c | z;
            COND_GE: pass_o = n ~^ v;
            COND_LT: pass_o = n ^ v;
            COND_GT: pass_o = ~z & (n ~^ v);
            COND_LE: pass_o = z | (n ^ v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b1;
            default: pass_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/cond_flag_unit.sv
// cond_flag_unit: NZCV flag register, conditional-execution gating and saturating annul counter.
// Optional COND_FLAG_SAVE_EN adds a shadow flag register with save/restore/swap.
module cond_flag_unit
    import cond_flag_unit_pkg::*;
#(
    parameter int         CNT_W    = 16,
    parameter logic [3:0] FLAG_RST = 4'b0000
) (
    input logic             clk,
    input logic             reset_n,
    cond_flag_unit_if.slave bus
);
    logic             pass;
    logic             cond_ex;
    logic [3:0]       wmask;
    logic [3:0]       alu_d;
    logic [3:0]       flags_d, flags_q;
    logic [CNT_W-1:0] annul_cnt_d, annul_cnt_q;

    cond_check u_check (
        .cond_i  (bus.cond),
        .flags_i (flags_q),
        .pass_o  (pass)
    );

    assign cond_ex       = bus.instr_valid & pass;
    assign bus.cond_ex   = cond_ex;
    assign bus.pc_src    = bus.pcs & cond_ex;
    assign bus.reg_write = bus.reg_w & cond_ex & ~bus.no_write;
    assign bus.mem_write = bus.mem_w & cond_ex;
    assign bus.flags_q   = flags_q;
    assign bus.annul_cnt = annul_cnt_q;

    // Each flag_w half enables its own pair of flag bits; a failed or bubble instruction writes nothing.
    assign wmask = cond_ex ? {{2{bus.flag_w[FLAG_W_NZ]}}, {2{bus.flag_w[FLAG_W_CV]}}} : 4'b0000;
    assign alu_d = (bus.alu_flags & wmask) | (flags_q & ~wmask);

    assign annul_cnt_d = bus.cnt_clr ? '0
                       : (bus.instr_valid & ~pass & ~(&annul_cnt_q)) ? annul_cnt_q + CNT_W'(1)
                       : annul_cnt_q;

`ifdef COND_FLAG_SAVE_EN
    logic [3:0] shadow_d, shadow_q;
    // Save always captures the pre-update flags, so save+restore swaps the two registers.
    assign shadow_d        = bus.save_req ? flags_q : shadow_q;
    assign flags_d         = bus.restore_req ? shadow_q : alu_d;
    assign bus.flags_saved = shadow_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) shadow_q <= FLAG_RST;
        else          shadow_q <= shadow_d;
    end
`else
    assign flags_d = alu_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q     <= FLAG_RST;
            annul_cnt_q <= '0;
        end else begin
            flags_q     <= flags_d;
            annul_cnt_q <= annul_cnt_d;
        end
    end
endmodule
